// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs req/gnt/rvalid bus transactions for loads/stores,
// aligns/extends load data and registers the write-back bundle. Optional MACC_MISALIGN_CHK_EN.
module mem_access #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk_sys,
   input  logic              rst_sys,
   input  logic              i_rd_wen,
   input  logic [4:0]        i_rd_addr,
   input  logic [XLEN-1:0]   i_result,
   input  logic              i_mem_wen,
   input  logic              i_mem_ren,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [XLEN-1:0]   i_mem_wdata,
   input  logic [3:0]        i_mem_wbe,
   input  logic [3:0]        i_mem_rdtype,
   output logic              o_stall,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [XLEN-1:0]   o_bus_wdata,
   output logic [3:0]        o_bus_be,
   input  logic              i_bus_gnt,
   input  logic              i_bus_rvalid,
   input  logic [XLEN-1:0]   i_bus_rdata,
   output logic              o_wb_rd_wen,
   output logic [4:0]        o_wb_rd_addr,
   output logic [XLEN-1:0]   o_wb_data,
   output logic              o_misalign
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              w_memOp;
   logic              w_isLoad;
   logic              w_complete;
   logic              w_misalign;
   logic [1:0]        w_offset;
   logic [3:0]        w_loadBe;
   logic [XLEN-1:0]   w_shifted;
   logic [XLEN-1:0]   w_loadData;
   logic              r_wbRdWen;
   logic [4:0]        r_wbRdAddr;
   logic [XLEN-1:0]   r_wbData;

   // Both ren and wen high is treated as a load.
   assign w_memOp  = i_mem_ren | i_mem_wen;
   assign w_isLoad = i_mem_ren;
   assign w_offset = i_mem_addr[1:0];

`ifdef MACC_MISALIGN_CHK_EN
   logic w_isHalf;
   logic w_isWord;
   logic r_misalign;

   always_comb begin
      w_isHalf = 1'b0;
      w_isWord = 1'b0;
      if (w_isLoad) begin
         w_isWord = i_mem_rdtype[2];
         w_isHalf = i_mem_rdtype[1] & ~i_mem_rdtype[2];
      end else begin
         case (i_mem_wbe)
            4'b1111:                   w_isWord = 1'b1;
            4'b0011, 4'b0110, 4'b1100: w_isHalf = 1'b1;
            default:                   w_isHalf = 1'b0;
         endcase
      end
      w_misalign = w_memOp & ((w_isHalf & w_offset[0]) | (w_isWord & (|w_offset)));
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_misalign & (r_state == IDLE);
      end
   end

   assign o_misalign = r_misalign;
`else
   assign w_misalign = 1'b0;
   assign o_misalign = 1'b0;
`endif

   always_comb begin
      if (i_mem_rdtype[2]) begin
         w_loadBe = 4'b1111;
      end else if (i_mem_rdtype[1]) begin
         w_loadBe = 4'b0011 << w_offset;
      end else begin
         w_loadBe = 4'b0001 << w_offset;
      end
   end

   assign o_bus_we    = i_mem_wen & ~i_mem_ren;
   assign o_bus_addr  = {i_mem_addr[ADDR_W-1:2], 2'b00};
   assign o_bus_wdata = i_mem_wdata;
   assign o_bus_be    = w_isLoad ? w_loadBe : i_mem_wbe;

   // Lanes shifted down by the byte offset, then narrowed and extended per load type.
   always_comb begin
      w_shifted = i_bus_rdata >> {w_offset, 3'b000};
      if (i_mem_rdtype[2]) begin
         w_loadData = w_shifted;
      end else if (i_mem_rdtype[1]) begin
         w_loadData = {{(XLEN-16){~i_mem_rdtype[3] & w_shifted[15]}}, w_shifted[15:0]};
      end else begin
         w_loadData = {{(XLEN-8){~i_mem_rdtype[3] & w_shifted[7]}}, w_shifted[7:0]};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_memOp && !w_misalign) begin
               if (!i_bus_gnt) begin
                  w_nextState = WAIT_GNT;
               end else if (w_isLoad) begin
                  w_nextState = WAIT_RVALID;
               end
            end
         end
         WAIT_GNT: begin
            if (i_bus_gnt) begin
               w_nextState = w_isLoad ? WAIT_RVALID : IDLE;
            end
         end
         WAIT_RVALID: begin
            if (i_bus_rvalid) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Request and stall are forced low while reset is asserted.
   always_comb begin
      o_bus_req  = 1'b0;
      w_complete = 1'b0;
      if (!rst_sys && w_memOp) begin
         case (r_state)
            IDLE: begin
               if (w_misalign) begin
                  w_complete = 1'b1;
               end else begin
                  o_bus_req  = 1'b1;
                  w_complete = i_bus_gnt & ~w_isLoad;
               end
            end
            WAIT_GNT: begin
               o_bus_req  = 1'b1;
               w_complete = i_bus_gnt & ~w_isLoad;
            end
            WAIT_RVALID: w_complete = i_bus_rvalid;
            default:     w_complete = 1'b0;
         endcase
      end
      o_stall = ~rst_sys & w_memOp & ~w_complete;
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         r_wbRdWen  <= 1'b0;
         r_wbRdAddr <= '0;
         r_wbData   <= '0;
      end else if (!w_memOp) begin
         r_wbRdWen  <= i_rd_wen;
         r_wbRdAddr <= i_rd_addr;
         r_wbData   <= i_result;
      end else if (w_complete) begin
         r_wbRdWen  <= i_rd_wen & w_isLoad & ~w_misalign;
         r_wbRdAddr <= i_rd_addr;
         r_wbData   <= (w_isLoad && !w_misalign) ? w_loadData : i_result;
      end else begin
         r_wbRdWen  <= 1'b0;
      end
   end

   assign o_wb_rd_wen  = r_wbRdWen;
   assign o_wb_rd_addr = r_wbRdAddr;
   assign o_wb_data    = r_wbData;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; covers the MACC_MISALIGN_CHK_EN build when defined.
module tb_mem_access;

   logic        clk_sys = 1'b0;
   logic        rst_sys;
   logic        i_rd_wen;
   logic [4:0]  i_rd_addr;
   logic [31:0] i_result;
   logic        i_mem_wen;
   logic        i_mem_ren;
   logic [31:0] i_mem_addr;
   logic [31:0] i_mem_wdata;
   logic [3:0]  i_mem_wbe;
   logic [3:0]  i_mem_rdtype;
   logic        o_stall;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_be;
   logic        i_bus_gnt;
   logic        i_bus_rvalid;
   logic [31:0] i_bus_rdata;
   logic        o_wb_rd_wen;
   logic [4:0]  o_wb_rd_addr;
   logic [31:0] o_wb_data;
   logic        o_misalign;

   int nAsserts = 0;
   int nFails   = 0;
   int stallCnt;
   int wbCnt;

   mem_access #(.ADDR_W(32), .XLEN(32)) dut (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr), .i_result(i_result),
      .i_mem_wen(i_mem_wen), .i_mem_ren(i_mem_ren), .i_mem_addr(i_mem_addr),
      .i_mem_wdata(i_mem_wdata), .i_mem_wbe(i_mem_wbe), .i_mem_rdtype(i_mem_rdtype),
      .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
      .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
      .o_wb_rd_wen(o_wb_rd_wen), .o_wb_rd_addr(o_wb_rd_addr), .o_wb_data(o_wb_data),
      .o_misalign(o_misalign)
   );

   always #5 clk_sys = ~clk_sys;

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic applyStimulus(input logic rdWen, input logic [4:0] rdAddr, input logic [31:0] result,
                                input logic ren, input logic wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wbe, input logic [3:0] rdtype,
                                input logic gnt, input logic rvalid, input logic [31:0] rdata);
      i_rd_wen     = rdWen;
      i_rd_addr    = rdAddr;
      i_result     = result;
      i_mem_ren    = ren;
      i_mem_wen    = wen;
      i_mem_addr   = addr;
      i_mem_wdata  = wdata;
      i_mem_wbe    = wbe;
      i_mem_rdtype = rdtype;
      i_bus_gnt    = gnt;
      i_bus_rvalid = rvalid;
      i_bus_rdata  = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset with a load presented: request and stall must stay low.
      rst_sys = 1'b1;
      applyStimulus(1, 5'd1, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0, 4'b0100, 1, 0, 32'h0);
      checkOutput("rst_req", {31'b0, o_bus_req}, 32'd0);
      checkOutput("rst_stall", {31'b0, o_stall}, 32'd0);
      tick();
      checkOutput("rst_wb_wen", {31'b0, o_wb_rd_wen}, 32'd0);
      checkOutput("rst_wb_addr", {27'b0, o_wb_rd_addr}, 32'd0);
      checkOutput("rst_wb_data", o_wb_data, 32'd0);
      checkOutput("rst_misalign", {31'b0, o_misalign}, 32'd0);

      // ALU op passes straight through in one cycle.
      rst_sys = 1'b0;
      applyStimulus(1, 5'd5, 32'h1234, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0, 32'h0);
      checkOutput("alu_stall", {31'b0, o_stall}, 32'd0);
      checkOutput("alu_req", {31'b0, o_bus_req}, 32'd0);
      tick();
      checkOutput("alu_wb_wen", {31'b0, o_wb_rd_wen}, 32'd1);
      checkOutput("alu_wb_addr", {27'b0, o_wb_rd_addr}, 32'd5);
      checkOutput("alu_wb_data", o_wb_data, 32'h1234);

      // LB at 0x103, gnt immediate, rvalid next cycle.
      applyStimulus(1, 5'd7, 32'h0, 1, 0, 32'h103, 32'h0, 4'h0, 4'b0001, 1, 0, 32'h0);
      checkOutput("lb_req", {31'b0, o_bus_req}, 32'd1);
      checkOutput("lb_we", {31'b0, o_bus_we}, 32'd0);
      checkOutput("lb_addr", o_bus_addr, 32'h100);
      checkOutput("lb_be", {28'b0, o_bus_be}, 32'b1000);
      checkOutput("lb_stall_gnt", {31'b0, o_stall}, 32'd1);
      tick();
      checkOutput("lb_bubble", {31'b0, o_wb_rd_wen}, 32'd0);
      applyStimulus(1, 5'd7, 32'h0, 1, 0, 32'h103, 32'h0, 4'h0, 4'b0001, 0, 1, 32'h80FFFFFF);
      checkOutput("lb_req_rv", {31'b0, o_bus_req}, 32'd0);
      checkOutput("lb_stall_rv", {31'b0, o_stall}, 32'd0);
      tick();
      checkOutput("lb_wb_wen", {31'b0, o_wb_rd_wen}, 32'd1);
      checkOutput("lb_wb_addr", {27'b0, o_wb_rd_addr}, 32'd7);
      checkOutput("lb_wb_data", o_wb_data, 32'hFFFFFF80);

      // LBU, same access, zero-extended.
      applyStimulus(1, 5'd8, 32'h0, 1, 0, 32'h103, 32'h0, 4'h0, 4'b1001, 1, 0, 32'h0);
      tick();
      applyStimulus(1, 5'd8, 32'h0, 1, 0, 32'h103, 32'h0, 4'h0, 4'b1001, 0, 1, 32'h80FFFFFF);
      tick();
      checkOutput("lbu_wb_wen", {31'b0, o_wb_rd_wen}, 32'd1);
      checkOutput("lbu_wb_data", o_wb_data, 32'h00000080);

      // LH at 0x102 with gnt delayed 3 cycles: 4 stall cycles and exactly one WB write.
      stallCnt = 0;
      wbCnt    = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 5'd9, 32'h0, 1, 0, 32'h102, 32'h0, 4'h0, 4'b0010, 0, 0, 32'h0);
         checkOutput("lh_req_wait", {31'b0, o_bus_req}, 32'd1);
         checkOutput("lh_addr_wait", o_bus_addr, 32'h100);
         checkOutput("lh_be_wait", {28'b0, o_bus_be}, 32'b1100);
         stallCnt += int'(o_stall);
         tick();
         wbCnt += int'(o_wb_rd_wen);
      end
      applyStimulus(1, 5'd9, 32'h0, 1, 0, 32'h102, 32'h0, 4'h0, 4'b0010, 1, 0, 32'h0);
      checkOutput("lh_req_gnt", {31'b0, o_bus_req}, 32'd1);
      stallCnt += int'(o_stall);
      tick();
      wbCnt += int'(o_wb_rd_wen);
      applyStimulus(1, 5'd9, 32'h0, 1, 0, 32'h102, 32'h0, 4'h0, 4'b0010, 0, 1, 32'hBEEF0000);
      stallCnt += int'(o_stall);
      tick();
      checkOutput("lh_wb_data", o_wb_data, 32'hFFFFBEEF);
      checkOutput("lh_wb_addr", {27'b0, o_wb_rd_addr}, 32'd9);
      wbCnt += int'(o_wb_rd_wen);
      applyStimulus(0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0, 32'h0);
      tick();
      wbCnt += int'(o_wb_rd_wen);
      checkOutput("lh_stall_cycles", stallCnt, 32'd4);
      checkOutput("lh_wb_writes", wbCnt, 32'd1);

      // SW at 0x200, gnt after 2 cycles; stall drops on the gnt cycle.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 5'd10, 32'h77, 0, 1, 32'h200, 32'hDEADBEEF, 4'hF, 4'h0, 0, 0, 32'h0);
         checkOutput("sw_req_wait", {31'b0, o_bus_req}, 32'd1);
         checkOutput("sw_stall_wait", {31'b0, o_stall}, 32'd1);
         tick();
      end
      applyStimulus(1, 5'd10, 32'h77, 0, 1, 32'h200, 32'hDEADBEEF, 4'hF, 4'h0, 1, 0, 32'h0);
      checkOutput("sw_req", {31'b0, o_bus_req}, 32'd1);
      checkOutput("sw_we", {31'b0, o_bus_we}, 32'd1);
      checkOutput("sw_addr", o_bus_addr, 32'h200);
      checkOutput("sw_wdata", o_bus_wdata, 32'hDEADBEEF);
      checkOutput("sw_be", {28'b0, o_bus_be}, 32'hF);
      checkOutput("sw_stall_gnt", {31'b0, o_stall}, 32'd0);
      tick();
      checkOutput("sw_wb_wen", {31'b0, o_wb_rd_wen}, 32'd0);

      // Reset while waiting for rvalid abandons the load; a later rvalid is ignored.
      applyStimulus(1, 5'd3, 32'h0, 1, 0, 32'h300, 32'h0, 4'h0, 4'b0100, 1, 0, 32'h0);
      tick();
      applyStimulus(1, 5'd3, 32'h0, 1, 0, 32'h300, 32'h0, 4'h0, 4'b0100, 0, 0, 32'h0);
      checkOutput("rv_wait_stall", {31'b0, o_stall}, 32'd1);
      checkOutput("rv_wait_req", {31'b0, o_bus_req}, 32'd0);
      rst_sys = 1'b1;
      #1;
      checkOutput("midrst_stall", {31'b0, o_stall}, 32'd0);
      tick();
      checkOutput("midrst_wb_wen", {31'b0, o_wb_rd_wen}, 32'd0);
      rst_sys = 1'b0;
      applyStimulus(1, 5'd4, 32'h55, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 1, 32'hAAAA);
      tick();
      checkOutput("stray_rv_wen", {31'b0, o_wb_rd_wen}, 32'd1);
      checkOutput("stray_rv_data", o_wb_data, 32'h55);
      applyStimulus(1, 5'd4, 32'h0, 1, 0, 32'h400, 32'h0, 4'h0, 4'b0100, 1, 0, 32'h0);
      checkOutput("postrst_req", {31'b0, o_bus_req}, 32'd1);
      tick();
      applyStimulus(1, 5'd4, 32'h0, 1, 0, 32'h400, 32'h0, 4'h0, 4'b0100, 0, 1, 32'hCAFEF00D);
      tick();
      checkOutput("postrst_lw_data", o_wb_data, 32'hCAFEF00D);
      checkOutput("postrst_lw_wen", {31'b0, o_wb_rd_wen}, 32'd1);

`ifdef MACC_MISALIGN_CHK_EN
      // Misaligned LW: no bus request, one-cycle flag, no write-back.
      applyStimulus(1, 5'd6, 32'h0, 1, 0, 32'h101, 32'h0, 4'h0, 4'b0100, 1, 0, 32'h0);
      checkOutput("mis_req", {31'b0, o_bus_req}, 32'd0);
      checkOutput("mis_stall", {31'b0, o_stall}, 32'd0);
      tick();
      checkOutput("mis_flag", {31'b0, o_misalign}, 32'd1);
      checkOutput("mis_wb_wen", {31'b0, o_wb_rd_wen}, 32'd0);
      applyStimulus(0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0, 32'h0);
      tick();
      checkOutput("mis_flag_clear", {31'b0, o_misalign}, 32'd0);
`else
      // Misaligned LW issued as-is; data shifted by the byte offset, upper lanes dropped.
      applyStimulus(1, 5'd6, 32'h0, 1, 0, 32'h101, 32'h0, 4'h0, 4'b0100, 1, 0, 32'h0);
      checkOutput("mis_req", {31'b0, o_bus_req}, 32'd1);
      checkOutput("mis_addr", o_bus_addr, 32'h100);
      checkOutput("mis_be", {28'b0, o_bus_be}, 32'hF);
      tick();
      applyStimulus(1, 5'd6, 32'h0, 1, 0, 32'h101, 32'h0, 4'h0, 4'b0100, 0, 1, 32'h11223344);
      tick();
      checkOutput("mis_wb_data", o_wb_data, 32'h00112233);
      checkOutput("mis_flag", {31'b0, o_misalign}, 32'd0);
      applyStimulus(0, 5'd0, 32'h0, 1, 0, 32'h103, 32'h0, 4'h0, 4'b0010, 0, 0, 32'h0);
      checkOutput("mis_lh_be", {28'b0, o_bus_be}, 32'b1000);
`endif

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage between the execute stage and write-back. It consumes the execute stage's registered memory controls, ALU result and destination-register controls. For loads and stores it runs a req/gnt/rvalid data-bus transaction and stalls the upstream pipeline until the access completes. It aligns and extends load data, then presents a registered write-back bundle whose data also serves as the write-back forwarding source.

## Interface
Parameters:
- ADDR_W, 32, data-bus address width
- XLEN, 32, data width

Ports:
- clk_sys  in  1  system clock; one clock domain
- rst_sys  in  1  reset; synchronous, active-high
- i_rd_wen  in  1  destination write enable from execute
- i_rd_addr  in  5  destination register index
- i_result  in  32  ALU result (non-memory write-back value)
- i_mem_wen  in  1  store request
- i_mem_ren  in  1  load request
- i_mem_addr  in  32  byte address
- i_mem_wdata  in  32  store data, already lane-aligned
- i_mem_wbe  in  4  store byte enables
- i_mem_rdtype  in  4  load type: bit0 byte, bit1 half, bit2 word, bit3 zero-extend
- o_stall  out  1  hold execute and earlier stages this cycle
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  32  {i_mem_addr[31:2],2'b00}
- o_bus_wdata  out  32  store data
- o_bus_be  out  4  byte enables
- i_bus_gnt  in  1  request accepted
- i_bus_rvalid  in  1  read data valid
- i_bus_rdata  in  32  read data word
- o_wb_rd_wen  out  1  registered write-back enable
- o_wb_rd_addr  out  5  registered write-back index
- o_wb_data  out  32  registered write-back data (forwarding source)
- o_misalign  out  1  registered misaligned-access flag (macro-dependent)

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE with no ren/wen: bundle {i_rd_wen, i_rd_addr, i_result} is registered to WB next edge; o_stall=0.
- IDLE with ren or wen: o_bus_req=1 combinationally.
  - No gnt: go to WAIT_GNT.
  - gnt on a load: go to WAIT_RVALID.
  - gnt on a store: access completes this cycle, stay in IDLE.
- WAIT_GNT: req held high; addr, we, wdata and be are held stable until gnt. Same gnt rules as IDLE.
- WAIT_RVALID: req=0. On rvalid the load completes; go to IDLE.
- Load bus enables: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111. Store bus enables = i_mem_wbe.
- Load data: shift i_bus_rdata right by 8*addr[1:0], take the low 8/16/32 bits, then sign-extend (bit3=0) or zero-extend (bit3=1).
- At completion, the WB bundle is {i_rd_wen, i_rd_addr, load data or i_result}.
- Stores always register o_wb_rd_wen=0.
- While a memory op is pending (not completing this cycle), the WB bundle registers a bubble (rd_wen=0).
- o_stall = memory op present AND not completing this cycle. Upstream inputs are guaranteed stable while o_stall=1.
- Protocol: i_bus_rvalid arrives no earlier than one cycle after gnt. rvalid seen outside WAIT_RVALID is ignored.
- ren and wen both high is illegal. It is treated as a load.

## Timing
- Reset (synchronous): state=IDLE; o_wb_rd_wen=0; o_wb_rd_addr=0; o_wb_data=0; o_misalign=0.
- During reset, o_bus_req=0 and o_stall=0.
- Reset mid-transaction abandons it; no write-back occurs.
- Latencies:
  - Non-memory op: 1 cycle to WB outputs.
  - Store: gnt cycle + 1.
  - Load: rvalid cycle + 1. Minimum 2 cycles stall-free path: gnt in cycle N, rvalid in N+1, WB valid in N+2, o_stall high in cycle N only.
- Unlimited gnt and rvalid wait; no timeout.

## Configuration
- MACC_MISALIGN_CHK_EN defined:
  - Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0; stores are checked by the same rule using the wbe span.
  - A misaligned access issues no bus request.
  - It completes in 1 cycle with o_wb_rd_wen=0 and o_misalign=1 for one cycle.
- Macro undefined:
  - o_misalign is tied 0.
  - Misaligned accesses are issued as-is; lanes beyond byte 3 are dropped.

## Test plan
- ALU op: rd_wen=1, rd=5, result=0x1234 → next cycle o_wb_rd_wen=1, rd=5, data=0x1234; o_stall never high.
- LB: addr=0x103, rdata=0x80FFFFFF, gnt immediate, rvalid +1 → o_bus_addr=0x100, be=4'b1000, o_wb_data=0xFFFFFF80. Same access with LBU → 0x00000080.
- LH: addr=0x102, rdata=0xBEEF0000 → o_wb_data=0xFFFFBEEF. gnt delayed 3 cycles → req/addr stable, o_stall high 4 cycles total, one WB write.
- SW: addr=0x200, wdata=0xDEADBEEF, wbe=4'hF, gnt after 2 cycles → we=1 bus write with exact fields, o_wb_rd_wen=0, stall released on the gnt cycle.
- rst_sys asserted while in WAIT_RVALID → state IDLE, no WB write. A later rvalid pulse is ignored.
- With MACC_MISALIGN_CHK_EN, LW at 0x101 → no o_bus_req, o_misalign=1 one cycle, o_wb_rd_wen=0.
